// File: rtl/nf_sume_10g_gt_reset_sequencer_pkg.sv
// Shared types for the per-port GT/PCS reset sequencer: one-hot state encoding,
// registered control bundle and its state decode, timer width helper.
package nf_sume_10g_gt_reset_sequencer_pkg;

  typedef enum logic [8:0] {
    S_IDLE      = 9'b000000001,
    S_WAIT_QPLL = 9'b000000010,
    S_HOLD      = 9'b000000100,
    S_WAIT_TX   = 9'b000001000,
    S_WAIT_RX   = 9'b000010000,
    S_WAIT_LOCK = 9'b000100000,
    S_READY     = 9'b001000000,
    S_RETRY     = 9'b010000000,
    S_FAULT     = 9'b100000000
  } state_t;

  typedef struct packed {
    logic gt_tx;
    logic gt_rx;
    logic pcs_tx;
    logic pcs_rx;
    logic link_ready;
    logic fault;
  } ctl_t;

  function automatic int unsigned timer_width(input int unsigned done_to,
                                              input int unsigned lock_to,
                                              input int unsigned hold);
    int unsigned m;
    m = (done_to > lock_to) ? done_to : lock_to;
    if (hold > m) m = hold;
    return $clog2(m + 1);
  endfunction

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = 6'b111100;
    case (s)
      S_WAIT_TX:   c.gt_tx = 1'b0;
      S_WAIT_RX:   begin
        c.gt_tx  = 1'b0;
        c.gt_rx  = 1'b0;
        c.pcs_tx = 1'b0;
      end
      S_WAIT_LOCK: c = 6'b000000;
      S_READY:     c = 6'b000010;
      S_FAULT:     c.fault = 1'b1;
      default:     ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/nf_sume_10g_gt_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for one asynchronous GT status bit into clk156.
module nf_sume_10g_sync_bit #(
  parameter int unsigned C_NUM_SYNC_REGS = 3
) (
  input  logic clk156,
  input  logic areset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [C_NUM_SYNC_REGS-1:0] chain;

  always_ff @(posedge clk156 or posedge areset) begin
    if (areset) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < C_NUM_SYNC_REGS; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[C_NUM_SYNC_REGS-1];

endmodule

// File: rtl/nf_sume_10g_gt_reset_sequencer.sv
// Per-port GTX/PCS reset sequencer: orders GT TX, GT RX, PCS TX, PCS RX reset
// release, waits for resetdone/block lock, retries on timeout, reports link_ready.
module nf_sume_10g_gt_reset_sequencer
  import nf_sume_10g_gt_reset_sequencer_pkg::*;
#(
  parameter int unsigned C_HOLD_CYCLES   = 16,
  parameter int unsigned C_DONE_TIMEOUT  = 65535,
  parameter int unsigned C_LOCK_TIMEOUT  = 65535,
  parameter int unsigned C_MAX_RETRY     = 7,
  parameter int unsigned C_NUM_SYNC_REGS = 3
) (
  input  logic       clk156,
  input  logic       areset,
  input  logic       reset_counter_done,
  input  logic       gtreset_in,
  input  logic       qplllock,
  input  logic       txresetdone,
  input  logic       rxresetdone,
  input  logic       rx_block_lock,
  output logic       gt_txreset,
  output logic       gt_rxreset,
  output logic       pcs_tx_reset,
  output logic       pcs_rx_reset,
  output logic       link_ready,
  output logic       fault,
  output logic [3:0] retry_count
);

  localparam int unsigned TW = timer_width(C_DONE_TIMEOUT, C_LOCK_TIMEOUT, C_HOLD_CYCLES);
  localparam logic [TW-1:0] HOLD_T = TW'(C_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] DONE_T = TW'(C_DONE_TIMEOUT);
  localparam logic [TW-1:0] LOCK_T = TW'(C_LOCK_TIMEOUT);
  localparam logic [3:0]    MAX_R  = 4'(C_MAX_RETRY);

  logic          qplllock_s, txresetdone_s, rxresetdone_s;
  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_limit;
  logic          restart, qpll_lost, retry_inc;
  ctl_t          ctl_q;

  nf_sume_10g_sync_bit #(.C_NUM_SYNC_REGS(C_NUM_SYNC_REGS)) u_sync_qpll (
    .clk156(clk156), .areset(areset), .d(qplllock), .q(qplllock_s));
  nf_sume_10g_sync_bit #(.C_NUM_SYNC_REGS(C_NUM_SYNC_REGS)) u_sync_tx (
    .clk156(clk156), .areset(areset), .d(txresetdone), .q(txresetdone_s));
  nf_sume_10g_sync_bit #(.C_NUM_SYNC_REGS(C_NUM_SYNC_REGS)) u_sync_rx (
    .clk156(clk156), .areset(areset), .d(rxresetdone), .q(rxresetdone_s));

  always_comb begin
    state_nxt   = state;
    retry_inc   = 1'b0;
    restart     = gtreset_in && (state != S_IDLE) && (state != S_FAULT);
    qpll_lost   = !qplllock_s &&
                  (state inside {S_HOLD, S_WAIT_TX, S_WAIT_RX, S_WAIT_LOCK, S_READY});
    timer_limit = (state == S_HOLD) ? HOLD_T :
                  (state == S_WAIT_LOCK) ? LOCK_T : DONE_T;
    case (state)
      S_IDLE:  if (reset_counter_done) state_nxt = S_WAIT_QPLL;
      S_FAULT: state_nxt = S_FAULT;
      default: begin
        if (gtreset_in) state_nxt = S_HOLD;
        else if (qpll_lost) state_nxt = S_WAIT_QPLL;
        else begin
          // done/lock checks precede the timeout so they win on a tie
          case (state)
            S_WAIT_QPLL: if (qplllock_s) state_nxt = S_HOLD;
            S_HOLD:      if (timer == HOLD_T) state_nxt = S_WAIT_TX;
            S_WAIT_TX:   if (txresetdone_s) state_nxt = S_WAIT_RX;
                         else if (timer == DONE_T) state_nxt = S_RETRY;
            S_WAIT_RX:   if (rxresetdone_s) state_nxt = S_WAIT_LOCK;
                         else if (timer == DONE_T) state_nxt = S_RETRY;
            S_WAIT_LOCK: if (rx_block_lock) state_nxt = S_READY;
                         else if (timer == LOCK_T) state_nxt = S_RETRY;
            S_READY:     if (!rx_block_lock) state_nxt = S_WAIT_LOCK;
            S_RETRY:     if (retry_count == MAX_R) state_nxt = S_FAULT;
                         else begin
                           state_nxt = S_HOLD;
                           retry_inc = 1'b1;
                         end
            default:     state_nxt = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the entry edge.
  always_ff @(posedge clk156 or posedge areset) begin
    if (areset) begin
      state       <= S_IDLE;
      timer       <= '0;
      retry_count <= '0;
      ctl_q       <= decode(S_IDLE);
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || restart) timer <= '0;
      else if (timer != timer_limit) timer <= timer + TW'(1);
      if ((state_nxt == S_READY) && (state != S_READY)) retry_count <= '0;
      else if (retry_inc && (retry_count != '1)) retry_count <= retry_count + 4'd1;
      ctl_q <= decode(state_nxt);
    end
  end

  assign gt_txreset   = ctl_q.gt_tx;
  assign gt_rxreset   = ctl_q.gt_rx;
  assign pcs_tx_reset = ctl_q.pcs_tx;
  assign pcs_rx_reset = ctl_q.pcs_rx;
  assign link_ready   = ctl_q.link_ready;
  assign fault        = ctl_q.fault;

endmodule

// File: tb/tb_nf_sume_10g_gt_reset_sequencer.sv
// Directed bench for the GT reset sequencer with hold = 4, timeouts = 100.
module tb_nf_sume_10g_gt_reset_sequencer;

  logic       clk156, areset, reset_counter_done, gtreset_in, qplllock;
  logic       txresetdone, rxresetdone, rx_block_lock;
  logic       gt_txreset, gt_rxreset, pcs_tx_reset, pcs_rx_reset, link_ready, fault;
  logic [3:0] retry_count;
  logic [5:0] ctl;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // {gt_txreset, gt_rxreset, pcs_tx_reset, pcs_rx_reset, link_ready, fault}
  localparam logic [5:0] ALLRST = 6'b111100;
  localparam logic [5:0] WTX    = 6'b011100;
  localparam logic [5:0] WRX    = 6'b000100;
  localparam logic [5:0] WLOCK  = 6'b000000;
  localparam logic [5:0] RDY    = 6'b000010;
  localparam logic [5:0] FLT    = 6'b111101;

  assign ctl = {gt_txreset, gt_rxreset, pcs_tx_reset, pcs_rx_reset, link_ready, fault};

  nf_sume_10g_gt_reset_sequencer #(
    .C_HOLD_CYCLES(4), .C_DONE_TIMEOUT(100), .C_LOCK_TIMEOUT(100),
    .C_MAX_RETRY(7), .C_NUM_SYNC_REGS(3)
  ) dut (
    .clk156(clk156), .areset(areset), .reset_counter_done(reset_counter_done),
    .gtreset_in(gtreset_in), .qplllock(qplllock), .txresetdone(txresetdone),
    .rxresetdone(rxresetdone), .rx_block_lock(rx_block_lock),
    .gt_txreset(gt_txreset), .gt_rxreset(gt_rxreset), .pcs_tx_reset(pcs_tx_reset),
    .pcs_rx_reset(pcs_rx_reset), .link_ready(link_ready), .fault(fault),
    .retry_count(retry_count)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; reset_counter_done = 1'b0; gtreset_in = 1'b0; qplllock = 1'b0;
    txresetdone = 1'b0; rxresetdone = 1'b0; rx_block_lock = 1'b0;
    #3;
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL reset_async_ctl: got %b expected %b", ctl, ALLRST); end
    n_checks++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", retry_count); end
    tick(3);
    areset = 1'b0;
    tick(2);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL reset_idle_ctl: got %b expected %b", ctl, ALLRST); end
  endtask

  task automatic test_nominal();
    reset_counter_done = 1'b1; qplllock = 1'b1;
    tick(7);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL nominal_hold_end: got %b expected %b", ctl, ALLRST); end
    tick(1);
    n_checks++; if (ctl !== WTX) begin n_fail++; $display("FAIL nominal_txreset_fall: got %b expected %b", ctl, WTX); end
    txresetdone = 1'b1; rxresetdone = 1'b1; rx_block_lock = 1'b1;
    tick(4);
    n_checks++; if (ctl !== WRX) begin n_fail++; $display("FAIL nominal_wait_rx: got %b expected %b", ctl, WRX); end
    tick(1);
    n_checks++; if (ctl !== WLOCK) begin n_fail++; $display("FAIL nominal_wait_lock: got %b expected %b", ctl, WLOCK); end
    tick(1);
    n_checks++; if (ctl !== RDY) begin n_fail++; $display("FAIL nominal_ready: got %b expected %b", ctl, RDY); end
    n_checks++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL nominal_retry: got %0d expected 0", retry_count); end
  endtask

  task automatic test_lock_flap();
    rx_block_lock = 1'b0;
    tick(1);
    n_checks++; if (ctl !== WLOCK) begin n_fail++; $display("FAIL flap_link_drop: got %b expected %b", ctl, WLOCK); end
    for (int i = 0; i < 9; i++) begin
      tick(1);
      n_checks++; if (ctl !== WLOCK) begin n_fail++; $display("FAIL flap_hold_%0d: got %b expected %b", i, ctl, WLOCK); end
    end
    rx_block_lock = 1'b1;
    tick(1);
    n_checks++; if (ctl !== RDY) begin n_fail++; $display("FAIL flap_relock: got %b expected %b", ctl, RDY); end
  endtask

  task automatic test_qpll_loss();
    qplllock = 1'b0;
    tick(3);
    n_checks++; if (ctl !== RDY) begin n_fail++; $display("FAIL qpll_sync_delay: got %b expected %b", ctl, RDY); end
    tick(1);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL qpll_loss_resets: got %b expected %b", ctl, ALLRST); end
    qplllock = 1'b1;
    tick(7);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL qpll_relock_hold: got %b expected %b", ctl, ALLRST); end
    tick(1);
    n_checks++; if (ctl !== WTX) begin n_fail++; $display("FAIL qpll_relock_wait_tx: got %b expected %b", ctl, WTX); end
    tick(1);
    n_checks++; if (ctl !== WRX) begin n_fail++; $display("FAIL qpll_relock_wait_rx: got %b expected %b", ctl, WRX); end
    tick(2);
    n_checks++; if (ctl !== RDY) begin n_fail++; $display("FAIL qpll_relock_ready: got %b expected %b", ctl, RDY); end
    n_checks++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL qpll_retry: got %0d expected 0", retry_count); end
  endtask

  task automatic test_gtreset();
    rxresetdone = 1'b0; gtreset_in = 1'b1;
    tick(1);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL gtreset_from_ready: got %b expected %b", ctl, ALLRST); end
    gtreset_in = 1'b0;
    tick(4);
    n_checks++; if (ctl !== WTX) begin n_fail++; $display("FAIL gtreset_wait_tx: got %b expected %b", ctl, WTX); end
    tick(1);
    n_checks++; if (ctl !== WRX) begin n_fail++; $display("FAIL gtreset_wait_rx: got %b expected %b", ctl, WRX); end
    rxresetdone = 1'b1;
    tick(3);
    n_checks++; if (ctl !== WRX) begin n_fail++; $display("FAIL gtreset_rx_sync: got %b expected %b", ctl, WRX); end
    gtreset_in = 1'b1;
    tick(1);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL gtreset_wins: got %b expected %b", ctl, ALLRST); end
    n_checks++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL gtreset_retry: got %0d expected 0", retry_count); end
    gtreset_in = 1'b0;
    tick(7);
    n_checks++; if (ctl !== RDY) begin n_fail++; $display("FAIL gtreset_ready: got %b expected %b", ctl, RDY); end
  endtask

  task automatic test_areset_mid();
    rx_block_lock = 1'b0;
    tick(1);
    n_checks++; if (ctl !== WLOCK) begin n_fail++; $display("FAIL areset_pre_wait_lock: got %b expected %b", ctl, WLOCK); end
    #3 areset = 1'b1;
    #1;
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL areset_async_ctl: got %b expected %b", ctl, ALLRST); end
    tick(2);
    reset_counter_done = 1'b0;
    areset = 1'b0;
    tick(3);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL areset_idle: got %b expected %b", ctl, ALLRST); end
    reset_counter_done = 1'b1;
    tick(5);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL areset_restart_hold: got %b expected %b", ctl, ALLRST); end
    tick(1);
    n_checks++; if (ctl !== WTX) begin n_fail++; $display("FAIL areset_restart_wait_tx: got %b expected %b", ctl, WTX); end
  endtask

  task automatic test_tx_timeout();
    areset = 1'b1; txresetdone = 1'b0; rxresetdone = 1'b0; rx_block_lock = 1'b0;
    tick(1);
    areset = 1'b0;
    tick(8);
    n_checks++; if (ctl !== WTX) begin n_fail++; $display("FAIL txto_wait_tx: got %b expected %b", ctl, WTX); end
    tick(100);
    n_checks++; if (ctl !== WTX) begin n_fail++; $display("FAIL txto_timer_limit: got %b expected %b", ctl, WTX); end
    tick(1);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL txto_retry_state: got %b expected %b", ctl, ALLRST); end
    n_checks++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL txto_retry_pre: got %0d expected 0", retry_count); end
    tick(1);
    n_checks++; if (retry_count !== 4'd1) begin n_fail++; $display("FAIL txto_retry_1: got %0d expected 1", retry_count); end
    for (int k = 2; k <= 7; k++) begin
      tick(106);
      n_checks++; if (retry_count !== 4'(k)) begin n_fail++; $display("FAIL txto_retry_%0d: got %0d expected %0d", k, retry_count, k); end
    end
    tick(105);
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL txto_last_retry: got %b expected %b", ctl, ALLRST); end
    tick(1);
    n_checks++; if (ctl !== FLT) begin n_fail++; $display("FAIL txto_fault: got %b expected %b", ctl, FLT); end
    n_checks++; if (retry_count !== 4'd7) begin n_fail++; $display("FAIL txto_fault_retry: got %0d expected 7", retry_count); end
    txresetdone = 1'b1; gtreset_in = 1'b1;
    tick(1);
    gtreset_in = 1'b0;
    tick(20);
    n_checks++; if (ctl !== FLT) begin n_fail++; $display("FAIL txto_fault_sticky: got %b expected %b", ctl, FLT); end
    #3 areset = 1'b1;
    #1;
    n_checks++; if (ctl !== ALLRST) begin n_fail++; $display("FAIL txto_fault_clear: got %b expected %b", ctl, ALLRST); end
    n_checks++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL txto_retry_clear: got %0d expected 0", retry_count); end
    tick(1);
    areset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_flap();
    test_qpll_loss();
    test_gtreset();
    test_areset_mid();
    test_tx_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
